// File: rtl/jogo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jogo_pkg
//  Description : Shared geometry, game constants, FSM state type and the
//                paddle-move helper for the game-logic stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package jogo_pkg;

    localparam logic [10:0] SCREEN_W    = 11'd640;
    localparam logic [10:0] SCREEN_H    = 11'd480;
    localparam logic [10:0] PADDLE_H    = 11'd90;
    localparam logic [10:0] PADDLE_STEP = 11'd4;
    localparam logic [10:0] BALL_SIZE   = 11'd8;
    localparam logic [10:0] BALL_STEP   = 11'd3;
    localparam logic [10:0] P1_FACE_X   = 11'd35;
    localparam logic [10:0] P2_FACE_X   = 11'd605;
    localparam logic [3:0]  WIN_SCORE   = 4'd9;
    localparam logic [5:0]  POINT_PAUSE = 6'd60;

    localparam logic [10:0] C_CENTRO_X       = (SCREEN_W - BALL_SIZE) >> 1;
    localparam logic [10:0] C_CENTRO_Y       = (SCREEN_H - BALL_SIZE) >> 1;
    localparam logic [10:0] C_PALETE_MAX_MIN = SCREEN_H - PADDLE_H;
    localparam logic [10:0] C_BOLA_LIM_Y     = SCREEN_H - BALL_SIZE;
    localparam logic [10:0] C_PALETE_INI     = (SCREEN_H - PADDLE_H) >> 1;

    typedef enum logic [1:0] {
        SAQUE = 2'd0,
        JOGO  = 2'd1,
        PONTO = 2'd2,
        FIM   = 2'd3
    } estado_t;

    // Next paddle top row; opposing buttons cancel out.
    function automatic logic [10:0] move_palete(input logic [10:0] ymin,
                                                input logic        sobe,
                                                input logic        desce);
        logic [10:0] novo;
        novo = ymin;
        if (sobe && !desce) begin
            novo = (ymin < PADDLE_STEP) ? 11'd0 : ymin - PADDLE_STEP;
        end else if (desce && !sobe) begin
            novo = (ymin >= C_PALETE_MAX_MIN - PADDLE_STEP) ? C_PALETE_MAX_MIN
                                                            : ymin + PADDLE_STEP;
        end
        return novo;
    endfunction

endpackage
`default_nettype wire

// File: rtl/logica_jogo_sincronizador.sv
`default_nettype none
// ============================================================================
//  Module      : sincronizador_botao
//  Description : Two-flop synchroniser for a raw button; the output is either
//                the synchronised level or a one-clock rising-edge pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module sincronizador_botao #(
    parameter bit BORDA = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic botao,
    output logic saida
);

    logic r_meta;
    logic r_sinc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sinc <= 1'b0;
        end else begin
            r_meta <= botao;
            r_sinc <= r_meta;
        end
    end

    generate
        if (BORDA) begin : g_borda
            logic r_ant;
            logic r_subida;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_ant    <= 1'b0;
                    r_subida <= 1'b0;
                end else begin
                    r_ant    <= r_sinc;
                    r_subida <= r_sinc & ~r_ant;
                end
            end

            assign saida = r_subida;
        end else begin : g_nivel
            assign saida = r_sinc;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/logica_jogo.sv
`default_nettype none
// ============================================================================
//  Module      : logica_jogo
//  Description : Pong game logic - paddles, ball, scores, serve LFSR and the
//                match FSM, all advancing once per frame_tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module logica_jogo
    import jogo_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        p1_up,
    input  logic        p1_down,
    input  logic        p2_up,
    input  logic        p2_down,
    input  logic        iniciar,
    output logic [10:0] palete1YMaximo,
    output logic [10:0] palete1YMinimo,
    output logic [10:0] palete2YMaximo,
    output logic [10:0] palete2Yminimo,
    output logic [10:0] bola_x,
    output logic [10:0] bola_y,
    output logic [3:0]  placar1,
    output logic [3:0]  placar2,
    output logic [3:0]  sorteio,
    output logic [1:0]  estado
);

    logic w_p1_up, w_p1_down, w_p2_up, w_p2_down, w_inicio_borda;

    sincronizador_botao #(.BORDA(1'b0)) u_sinc_p1_up   (.clock(clock), .reset_n(reset_n), .botao(p1_up),   .saida(w_p1_up));
    sincronizador_botao #(.BORDA(1'b0)) u_sinc_p1_down (.clock(clock), .reset_n(reset_n), .botao(p1_down), .saida(w_p1_down));
    sincronizador_botao #(.BORDA(1'b0)) u_sinc_p2_up   (.clock(clock), .reset_n(reset_n), .botao(p2_up),   .saida(w_p2_up));
    sincronizador_botao #(.BORDA(1'b0)) u_sinc_p2_down (.clock(clock), .reset_n(reset_n), .botao(p2_down), .saida(w_p2_down));
    sincronizador_botao #(.BORDA(1'b1)) u_sinc_iniciar (.clock(clock), .reset_n(reset_n), .botao(iniciar), .saida(w_inicio_borda));

    logic [3:0]  r_lfsr;
    logic        r_inicio_pend;
    estado_t     r_estado;
    logic [10:0] r_p1_min, r_p1_max, r_p2_min, r_p2_max;
    logic [10:0] r_bx, r_by;
    logic        r_dx, r_dy;
    logic [3:0]  r_placar1, r_placar2;
    logic [5:0]  r_pausa;

    // x^4 + x^3 + 1: the all-zero state is unreachable from the seed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= 4'b1001;
        end else begin
            r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
        end
    end

    // A start edge waits here until the next frame consumes it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inicio_pend <= 1'b0;
        end else if (frame_tick) begin
            r_inicio_pend <= 1'b0;
        end else if (w_inicio_borda) begin
            r_inicio_pend <= 1'b1;
        end
    end

    logic w_inicio;
    assign w_inicio = r_inicio_pend | w_inicio_borda;

    logic [10:0] w_p1_min, w_p2_min;
    assign w_p1_min = move_palete(r_p1_min, w_p1_up, w_p1_down);
    assign w_p2_min = move_palete(r_p2_min, w_p2_up, w_p2_down);

    logic [10:0] w_bx, w_by;
    logic        w_dx, w_dy;
    logic        w_sobre1, w_sobre2;
    logic        w_erro_esq, w_erro_dir;
    logic [3:0]  w_placar1_inc, w_placar2_inc;

    assign w_placar1_inc = r_placar1 + 4'd1;
    assign w_placar2_inc = r_placar2 + 4'd1;

    // One JOGO step: vertical first, then horizontal against the updated row.
    always_comb begin
        w_bx       = r_bx;
        w_by       = r_by;
        w_dx       = r_dx;
        w_dy       = r_dy;
        w_erro_esq = 1'b0;
        w_erro_dir = 1'b0;

        if (!r_dy) begin
            if (r_by < BALL_STEP) begin
                w_by = 11'd0;
                w_dy = 1'b1;
            end else begin
                w_by = r_by - BALL_STEP;
            end
        end else begin
            if (r_by + BALL_SIZE - 11'd1 + BALL_STEP > SCREEN_H - 11'd1) begin
                w_by = C_BOLA_LIM_Y;
                w_dy = 1'b0;
            end else begin
                w_by = r_by + BALL_STEP;
            end
        end

        w_sobre1 = (w_by <= r_p1_max) && (w_by + BALL_SIZE - 11'd1 >= r_p1_min);
        w_sobre2 = (w_by <= r_p2_max) && (w_by + BALL_SIZE - 11'd1 >= r_p2_min);

        if (!r_dx) begin
            if ((r_bx > P1_FACE_X) && (r_bx <= P1_FACE_X + BALL_STEP) && w_sobre1) begin
                w_bx = P1_FACE_X + 11'd1;
                w_dx = 1'b1;
            end else if (r_bx < BALL_STEP) begin
                w_erro_esq = 1'b1;
            end else begin
                w_bx = r_bx - BALL_STEP;
            end
        end else begin
            if ((r_bx + BALL_SIZE - 11'd1 < P2_FACE_X) &&
                (r_bx + BALL_SIZE - 11'd1 + BALL_STEP >= P2_FACE_X) && w_sobre2) begin
                w_bx = P2_FACE_X - BALL_SIZE;
                w_dx = 1'b0;
            end else if (r_bx + BALL_SIZE - 11'd1 + BALL_STEP > SCREEN_W - 11'd1) begin
                w_erro_dir = 1'b1;
            end else begin
                w_bx = r_bx + BALL_STEP;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado  <= SAQUE;
            r_p1_min  <= C_PALETE_INI;
            r_p1_max  <= C_PALETE_INI + PADDLE_H - 11'd1;
            r_p2_min  <= C_PALETE_INI;
            r_p2_max  <= C_PALETE_INI + PADDLE_H - 11'd1;
            r_bx      <= C_CENTRO_X;
            r_by      <= C_CENTRO_Y;
            r_dx      <= 1'b0;
            r_dy      <= 1'b0;
            r_placar1 <= 4'd0;
            r_placar2 <= 4'd0;
            r_pausa   <= 6'd0;
        end else if (frame_tick) begin
            if (r_estado != FIM) begin
                r_p1_min <= w_p1_min;
                r_p1_max <= w_p1_min + PADDLE_H - 11'd1;
                r_p2_min <= w_p2_min;
                r_p2_max <= w_p2_min + PADDLE_H - 11'd1;
            end

            case (r_estado)
                SAQUE: begin
                    r_bx <= C_CENTRO_X;
                    r_by <= C_CENTRO_Y;
                    if (w_inicio) begin
                        r_dx     <= r_lfsr[0];
                        r_dy     <= r_lfsr[1];
                        r_estado <= JOGO;
                    end
                end
                JOGO: begin
                    r_bx <= w_bx;
                    r_by <= w_by;
                    r_dx <= w_dx;
                    r_dy <= w_dy;
                    if (w_erro_esq) begin
                        r_placar2 <= w_placar2_inc;
                        r_pausa   <= POINT_PAUSE;
                        r_estado  <= (w_placar2_inc == WIN_SCORE) ? FIM : PONTO;
                    end else if (w_erro_dir) begin
                        r_placar1 <= w_placar1_inc;
                        r_pausa   <= POINT_PAUSE;
                        r_estado  <= (w_placar1_inc == WIN_SCORE) ? FIM : PONTO;
                    end
                end
                PONTO: begin
                    if (r_pausa <= 6'd1) begin
                        r_pausa  <= 6'd0;
                        r_bx     <= C_CENTRO_X;
                        r_by     <= C_CENTRO_Y;
                        r_dx     <= r_lfsr[0];
                        r_dy     <= r_lfsr[1];
                        r_estado <= JOGO;
                    end else begin
                        r_pausa <= r_pausa - 6'd1;
                    end
                end
                FIM: begin
                    if (w_inicio) begin
                        r_placar1 <= 4'd0;
                        r_placar2 <= 4'd0;
                        r_bx      <= C_CENTRO_X;
                        r_by      <= C_CENTRO_Y;
                        r_estado  <= SAQUE;
                    end
                end
                default: r_estado <= SAQUE;
            endcase
        end
    end

    assign palete1YMinimo = r_p1_min;
    assign palete1YMaximo = r_p1_max;
    assign palete2Yminimo = r_p2_min;
    assign palete2YMaximo = r_p2_max;
    assign bola_x         = r_bx;
    assign bola_y         = r_by;
    assign placar1        = r_placar1;
    assign placar2        = r_placar2;
    assign sorteio        = r_lfsr;
    assign estado         = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_logica_jogo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logica_jogo
//  Description : Directed self-checking bench for logica_jogo.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_logica_jogo;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
    logic        iniciar = 1'b0;
    logic [10:0] palete1YMaximo, palete1YMinimo, palete2YMaximo, palete2Yminimo;
    logic [10:0] bola_x, bola_y;
    logic [3:0]  placar1, placar2, sorteio;
    logic [1:0]  estado;

    int checks = 0;
    int errors = 0;

    always #10 clock = ~clock;

    logica_jogo u_dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .frame_tick     (frame_tick),
        .p1_up          (p1_up),
        .p1_down        (p1_down),
        .p2_up          (p2_up),
        .p2_down        (p2_down),
        .iniciar        (iniciar),
        .palete1YMaximo (palete1YMaximo),
        .palete1YMinimo (palete1YMinimo),
        .palete2YMaximo (palete2YMaximo),
        .palete2Yminimo (palete2Yminimo),
        .bola_x         (bola_x),
        .bola_y         (bola_y),
        .placar1        (placar1),
        .placar2        (placar2),
        .sorteio        (sorteio),
        .estado         (estado)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic settle();
        repeat (3) @(negedge clock);
    endtask

    // Frame tick issued only once sorteio shows the wanted serve bits.
    task automatic tick_sel(input logic [1:0] mask, input logic [1:0] want);
        int n;
        n = 0;
        @(negedge clock);
        while (((sorteio[1:0] & mask) != want) && (n < 40)) begin
            @(negedge clock);
            n++;
        end
        chk("sorteio_wait", int'(n < 40), 1);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
    endtask

    task automatic press_start();
        iniciar = 1'b1;
        repeat (4) @(negedge clock);
        iniciar = 1'b0;
        settle();
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_p1min"},  palete1YMinimo, 195);
        chk({t, "_p1max"},  palete1YMaximo, 284);
        chk({t, "_p2min"},  palete2Yminimo, 195);
        chk({t, "_p2max"},  palete2YMaximo, 284);
        chk({t, "_bx"},     bola_x, 316);
        chk({t, "_by"},     bola_y, 236);
        chk({t, "_placar1"}, placar1, 0);
        chk({t, "_placar2"}, placar2, 0);
        chk({t, "_estado"}, estado, 0);
        chk({t, "_sorteio"}, sorteio, 9);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2 ms");
        $fatal(1);
    end

    initial begin
        logic [3:0] prev;
        int         e;

        repeat (3) @(negedge clock);
        chk_reset("rst");
        reset_n = 1'b1;

        prev = sorteio;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("lfsr_nonzero", int'(sorteio != 4'd0), 1);
            chk("lfsr_step",    int'(sorteio != prev), 1);
            prev = sorteio;
        end

        // Left paddle up to the top edge and one tick beyond.
        p1_up = 1'b1;
        settle();
        for (int k = 1; k <= 50; k++) begin
            tick();
            e = (k < 49) ? 195 - 4 * k : 0;
            chk("p1_up_min", palete1YMinimo, e);
            chk("p1_up_max", palete1YMaximo, e + 89);
        end
        chk("saque_bx", bola_x, 316);
        chk("saque_by", bola_y, 236);
        chk("saque_estado", estado, 0);
        p1_up = 1'b0;

        // Right paddle down to the bottom, then both buttons together.
        p2_down = 1'b1;
        settle();
        for (int k = 1; k <= 60; k++) begin
            tick();
            e = (195 + 4 * k > 390) ? 390 : 195 + 4 * k;
            chk("p2_down_min", palete2Yminimo, e);
            chk("p2_down_max", palete2YMaximo, e + 89);
        end
        p2_up = 1'b1;
        settle();
        tick();
        chk("p2_both_min", palete2Yminimo, 390);
        chk("p2_both_max", palete2YMaximo, 479);
        p2_up = 1'b0;
        p2_down = 1'b0;
        settle();

        // Serve left/up; top bounce and a left-paddle hit (paddle at 0..89).
        press_start();
        tick_sel(2'b11, 2'b00);
        chk("serve_estado", estado, 1);
        chk("serve_bx", bola_x, 316);
        ticks(78);
        chk("up_by78", bola_y, 2);
        chk("up_bx78", bola_x, 82);
        tick();
        chk("top_by", bola_y, 0);
        chk("top_bx", bola_x, 79);
        tick();
        chk("top_next_by", bola_y, 3);
        chk("top_next_bx", bola_x, 76);
        ticks(13);
        chk("pre_hit_bx", bola_x, 37);
        chk("pre_hit_by", bola_y, 42);
        tick();
        chk("hit_bx", bola_x, 36);
        chk("hit_by", bola_y, 45);
        tick();
        chk("after_hit_bx", bola_x, 39);
        chk("after_hit_by", bola_y, 48);
        chk("hit_placar1", placar1, 0);
        chk("hit_placar2", placar2, 0);
        chk("hit_estado", estado, 1);

        // Left miss with the paddle at its start rows, then the pause.
        do_reset();
        press_start();
        tick_sel(2'b11, 2'b00);
        ticks(93);
        chk("miss_pre_bx", bola_x, 37);
        tick();
        chk("miss_pass_bx", bola_x, 34);
        ticks(11);
        chk("miss_edge_bx", bola_x, 1);
        chk("miss_edge_estado", estado, 1);
        tick();
        chk("miss_placar2", placar2, 1);
        chk("miss_placar1", placar1, 0);
        chk("miss_estado", estado, 2);
        chk("miss_bx", bola_x, 1);
        ticks(59);
        chk("pause59_estado", estado, 2);
        chk("pause59_bx", bola_x, 1);
        tick_sel(2'b11, 2'b01);
        chk("pause_end_estado", estado, 1);
        chk("pause_end_bx", bola_x, 316);
        chk("pause_end_by", bola_y, 236);
        tick();
        chk("reserve_bx", bola_x, 319);
        chk("reserve_by", bola_y, 233);

        // Nine right-side misses give player 1 the match.
        do_reset();
        press_start();
        tick_sel(2'b01, 2'b01);
        for (int p = 1; p <= 9; p++) begin
            ticks(105);
            chk("win_run_bx", bola_x, 631);
            chk("win_run_estado", estado, 1);
            tick();
            chk("win_placar1", placar1, p);
            chk("win_placar2", placar2, 0);
            if (p < 9) begin
                chk("win_pause_estado", estado, 2);
                if (p == 8) press_start();
                ticks(59);
                chk("win_pause59", estado, 2);
                tick_sel(2'b01, 2'b01);
                chk("win_resume_estado", estado, 1);
                chk("win_resume_bx", bola_x, 316);
            end else begin
                chk("fim_estado", estado, 3);
            end
        end
        ticks(2);
        chk("fim_hold_estado", estado, 3);
        chk("fim_hold_bx", bola_x, 631);
        p1_up = 1'b1;
        settle();
        tick();
        chk("fim_paddle_frozen", palete1YMinimo, 195);
        p1_up = 1'b0;
        settle();
        press_start();
        tick();
        chk("restart_placar1", placar1, 0);
        chk("restart_placar2", placar2, 0);
        chk("restart_estado", estado, 0);
        chk("restart_bx", bola_x, 316);
        chk("restart_by", bola_y, 236);

        // Asynchronous reset in the middle of a rally.
        press_start();
        tick_sel(2'b00, 2'b00);
        ticks(5);
        chk("async_pre_estado", estado, 1);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset("async");
        reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logica_jogo.md
Name: logica_jogo

Overview:
Game-logic stage directly upstream of the VGA display stage. It owns both paddle positions, the ball position and velocity, the scores and the serve randomiser, and produces the paddle Y-extents and `sorteio` values the display stage draws. All state updates once per video frame on a one-clock `frame_tick` pulse, which comes from the display timing. The free-running LFSR and the button synchronisers are the only logic that runs every clock.

Parameters:
SCREEN_W, 640, active width in pixels
SCREEN_H, 480, active height in pixels
PADDLE_H, 90, paddle height in pixels
PADDLE_STEP, 4, paddle pixels moved per frame
BALL_SIZE, 8, ball square side in pixels
BALL_STEP, 3, ball pixels moved per frame on each axis
P1_FACE_X, 35, right face of left paddle
P2_FACE_X, 605, left face of right paddle
WIN_SCORE, 9, points needed to win
POINT_PAUSE, 60, frames frozen after a point

Ports:
clock  in  1  50 MHz system clock
reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-clock pulse per frame
p1_up, p1_down, p2_up, p2_down  in  1 each  raw buttons, active-high
iniciar  in  1  raw start button
palete1YMaximo, palete1YMinimo  out  11  left paddle bottom/top row
palete2YMaximo, palete2Yminimo  out  11  right paddle bottom/top row
bola_x, bola_y  out  11  ball top-left pixel
placar1, placar2  out  4  scores
sorteio  out  4  current LFSR value
estado  out  2  FSM state (SAQUE=0, JOGO=1, PONTO=2, FIM=3)

Behaviour:
- Reset values: paddle min = 195, paddle max = 284 (both paddles); bola_x = 316, bola_y = 236; scores 0; estado SAQUE; sorteio 4'b1001; dx and dy = 0.
- Every output is registered. All outputs change only on the clock after `frame_tick`, except `sorteio`, which changes every clock.
- Buttons pass through a 2-FF synchroniser. Start is the rising edge of the synchronised `iniciar`. That edge is latched and consumed at the next `frame_tick`.
- LFSR: 4-bit, polynomial x^4+x^3+1, shifts every clock, never reaches zero.
- Paddles (states SAQUE, JOGO, PONTO; frozen in FIM):
  - up only: min -= PADDLE_STEP, clamped at 0.
  - down only: min += PADDLE_STEP, clamped at SCREEN_H-PADDLE_H (390).
  - both or neither: no move.
  - max = min + PADDLE_H - 1 at all times.
- Paddle collision uses the paddle values registered before the current tick.
- FSM:
  - SAQUE: ball held at centre. On start: dx = sorteio[0] (1 = right), dy = sorteio[1] (1 = down), go to JOGO.
  - JOGO: ball update each tick, applied in this order:
    - Vertical, moving up: if y < BALL_STEP, then y = 0 and dy = down; else y -= BALL_STEP.
    - Vertical, moving down: if y + BALL_SIZE - 1 + BALL_STEP > SCREEN_H - 1, then y = 472 and dy = up; else y += BALL_STEP.
    - Left, hit: x > P1_FACE_X, x - BALL_STEP <= P1_FACE_X, and [y, y+7] overlaps [min1, max1]. Then x = P1_FACE_X + 1 and dx = right.
    - Left, miss: x < BALL_STEP. placar2++.
    - Right, hit: x+7 < P2_FACE_X, x + 7 + BALL_STEP >= P2_FACE_X, and overlap with paddle 2. Then x = P2_FACE_X - BALL_SIZE (597) and dx = left.
    - Right, miss: x + 7 + BALL_STEP > 639. placar1++.
    - Otherwise x moves by BALL_STEP in direction dx.
    - On a miss: if the new score equals WIN_SCORE, go to FIM; else go to PONTO with the pause counter = POINT_PAUSE.
  - PONTO: ball frozen at its miss position; counter decrements per tick. At 0: ball recentred, dx/dy taken from sorteio, go to JOGO.
  - FIM: ball and paddles frozen. On start: scores cleared, ball centred, go to SAQUE.
- A start edge during JOGO or PONTO is discarded.
- Reset asserted mid-game returns every output to its reset value immediately (asynchronous).
- Width: all geometry uses 11-bit unsigned arithmetic. Comparisons are arranged so that no subtraction underflows.

Decomposition:
- Package jogo_pkg:
  - estado_t enum.
  - Derived constants: centre X/Y, max paddle min (390), ball wall limit (472), paddle start min (195).
- One sub-module, sincronizador_botao: 2-FF synchroniser with rising-edge output. Instantiated once per button.
- The LFSR and FSM stay inline.

Test Plan:
- Reset, then hold p1_up for 49 ticks → palete1YMinimo steps 191, 187, … 3, then 0; palete1YMaximo ends at 89. A further tick stays at 0/89.
- Hold p2_down for 60 ticks → palete2Yminimo saturates at 390 and palete2Ymaximo at 479. Pressing up and down together → no change.
- Pulse iniciar; bench records sorteio on the start tick → estado = 1, and the ball moves (±3, ±3) per tick matching sorteio[1:0]. Ball reaching the top gives bola_y = 0, then 3.
- Park p1 paddle at 0..89 with the ball travelling left at y = 236 → miss: placar2 = 1, estado = 2. After 60 ticks the ball is at (316, 236) and estado = 1.
- Align p1 paddle with the ball travelling left → bola_x = 36 on the hit tick and 39 on the next tick; scores unchanged.
- Force 9 points to player 1 → estado = 3, ball frozen. iniciar pulse → placar1 = placar2 = 0, estado = 0. Assert reset_n = 0 mid-JOGO → all outputs return to reset values without waiting for a clock edge.
